program_sequencer: RTL

Instruction scheduler that sits between the debounced front-panel inputs and the CPU controller. It owns a small loadable program memory, filled one instruction at a time from the switches. It issues the stored instructions to the controller over a valid/ready handshake, either free-running or one instruction per button press. It replaces the fixed instruction case table with a user-programmable store and adds halt/step sequencing.

---
 rtl/program_sequencer_if.sv | 12 +
 rtl/program_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer_if.sv
// program_sequencer_if: instruction handshake between the sequencer and the CPU controller.
// The master presents instr/instr_valid; the slave answers with instr_ready.
interface program_sequencer_if #(
  parameter int IW = 8
);
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/program_sequencer.sv
// program_sequencer: small loadable program store fed from the front-panel switches.
// Stored instructions are issued to the CPU controller over valid/ready, either
// free-running (run button) or one per press (step button), halting at the last
// loaded entry or at LAST_ADDR, whichever comes first.
// Optional breakpoint/pause support is compiled in with `define SEQ_BREAKPOINT_EN.
module program_sequencer #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int IW        = 8,
  parameter int LAST_ADDR = 14
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [IW-1:0]       sw,
  input  logic                load_btn,
  input  logic                run_btn,
  input  logic                step_btn,
`ifdef SEQ_BREAKPOINT_EN
  input  logic [AW-1:0]       bp_addr,
  input  logic                bp_en,
`endif
  program_sequencer_if.master cpu,
  output logic [AW-1:0]       pc,
  output logic [AW:0]         prog_len,
  output logic                busy,
  output logic                halted
);

`ifdef SEQ_BREAKPOINT_EN
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_HALT, S_PAUSE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALT} state_t;
`endif

  localparam logic [AW:0] LAST_L  = LAST_ADDR[AW:0];
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  state_t        state_q, state_d, step_home;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          load_q, run_q, step_q;
  logic          mem_we;
  logic [IW-1:0] mem [DEPTH];

  logic          run_ev, step_ev, load_ev;
  logic [AW:0]   len_m1;
  logic [AW-1:0] end_addr, step_pc;
  logic          at_end, run_ok, step_ok, xfer, fetch, idle_like, bp_hit;

  // Button events with run > step > load priority; lower-priority events are dropped.
  assign run_ev  = run_btn & ~run_q;
  assign step_ev = step_btn & ~step_q & ~run_ev;
  assign load_ev = load_btn & ~load_q & ~run_ev & ~(step_btn & ~step_q);

  // Final issuable address; prog_len==0 is always screened out before end_addr is used.
  assign len_m1    = prog_len_q - 1'b1;
  assign end_addr  = (len_m1 > LAST_L) ? LAST_L[AW-1:0] : len_m1[AW-1:0];
  assign at_end    = (pc_q == end_addr);
  assign run_ok    = (prog_len_q != '0);
  assign xfer      = valid_q & cpu.instr_ready;
  assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT);

`ifdef SEQ_BREAKPOINT_EN
  logic skip_q, skip_d, pret_q, pret_d;
  assign bp_hit    = (state_q == S_RUN) & ~valid_q & bp_en & (pc_q == bp_addr) & ~skip_q;
  assign step_home = pret_q ? S_PAUSE : S_IDLE;
`else
  assign bp_hit    = 1'b0;
  assign step_home = S_IDLE;
`endif

  // A fresh instruction is read whenever RUN/STEP has nothing on the bus.
  assign fetch = ~valid_q & (((state_q == S_RUN) & ~bp_hit) | (state_q == S_STEP));

  // Step target: in HALT at the final entry, stepping wraps back to the start.
  // A step that lands on the final entry still issues it, then halts.
  always_comb begin
    step_pc = pc_q;
    if (state_q == S_HALT && at_end) step_pc = '0;
  end
  assign step_ok = run_ok && (step_pc <= end_addr);

  // Next-state: button events while parked, handshake completion while issuing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (run_ev)       state_d = run_ok  ? S_RUN  : S_HALT;
        else if (step_ev) state_d = step_ok ? S_STEP : S_HALT;
      end
      S_RUN: begin
        if (xfer && at_end) state_d = S_HALT;
`ifdef SEQ_BREAKPOINT_EN
        if (bp_hit) state_d = S_PAUSE;
`endif
      end
      S_STEP: begin
        if (xfer) state_d = at_end ? S_HALT : step_home;
      end
`ifdef SEQ_BREAKPOINT_EN
      S_PAUSE: begin
        if (run_ev)       state_d = S_RUN;
        else if (step_ev) state_d = S_STEP;
      end
`endif
      default: state_d = state_q;
    endcase
  end

  // Datapath next values: program loading, pc movement and the issue register.
  always_comb begin
    pc_d       = pc_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    mem_we     = 1'b0;
    if (idle_like) begin
      if (run_ev)                pc_d = '0;
      else if (step_ev && step_ok) pc_d = step_pc;
    end
    if (load_ev && state_q == S_IDLE) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (prog_len_q != DEPTH_L) prog_len_d = prog_len_q + 1'b1;
    end
    if (fetch) begin
      instr_d = mem[pc_q];
      valid_d = 1'b1;
    end
    if (xfer) begin
      valid_d = 1'b0;
      if (!at_end) pc_d = pc_q + 1'b1;
    end
  end

`ifdef SEQ_BREAKPOINT_EN
  // Breakpoint bookkeeping: skip the breakpoint once after resuming, and remember
  // that a step taken from PAUSE must return there.
  always_comb begin
    skip_d = skip_q;
    pret_d = pret_q;
    if (state_q == S_PAUSE && run_ev) skip_d = 1'b1;
    else if (fetch)                   skip_d = 1'b0;
    if (state_q == S_PAUSE && step_ev && !run_ev) pret_d = 1'b1;
    else if (state_q == S_STEP && xfer)           pret_d = 1'b0;
  end

  // Breakpoint flags register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      skip_q <= 1'b0;
      pret_q <= 1'b0;
    end else begin
      skip_q <= skip_d;
      pret_q <= pret_d;
    end
  end
`endif

  // State and datapath registers; clr clears everything except the memory array.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      load_q     <= 1'b0;
      run_q      <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      load_q     <= load_btn;
      run_q      <= run_btn;
      step_q     <= step_btn;
    end
  end

  // Program memory write port; prog_len decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= sw;
  end

  // Outputs decoded from registered state.
  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_STEP);
`ifdef SEQ_BREAKPOINT_EN
    if (state_q == S_PAUSE) busy = 1'b1;
`endif
    halted = (state_q == S_HALT);
  end

  assign cpu.instr       = instr_q;
  assign cpu.instr_valid = valid_q;
  assign pc              = pc_q;
  assign prog_len        = prog_len_q;

endmodule
